// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use, branch flush,
// data-memory waits with timeout, EX forwarding selects and stall counter.
module pipeline_hazard_ctrl #(
    parameter int REG_W   = 6,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemAccessM,
    input  logic             mem_ready,
    input  logic             BranchTakenE,
    output logic             enableF,
    output logic             enableD,
    output logic             enableE,
    output logic             enableM,
    output logic             enableW,
    output logic             flushD,
    output logic             flushE,
    output logic             bubbleW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_count,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam int WC_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [WC_W-1:0]   w_wait_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_terr;

    logic w_memstall;
    logic w_loaduse;
    logic w_enF, w_enD, w_enE, w_enM, w_enW;
    logic w_flD, w_flE, w_bub;
    logic [1:0] w_fa, w_fb;

    assign w_memstall = MemAccessM & ~mem_ready;

    assign w_loaduse = MemtoRegE & RegWriteE
                     & (WriteRegE != '0)
                     & ((WriteRegE == rsD) | (WriteRegE == rtD))
                     & ~BranchTakenE;

    always_comb begin
        w_next     = r_state;
        w_wait_nxt = r_wait_cnt;
        w_enF      = 1'b1;
        w_enD      = 1'b1;
        w_enE      = 1'b1;
        w_enM      = 1'b1;
        w_enW      = 1'b1;
        w_flD      = 1'b0;
        w_flE      = 1'b0;
        w_bub      = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_memstall) begin
                    w_enF      = 1'b0;
                    w_enD      = 1'b0;
                    w_enE      = 1'b0;
                    w_enM      = 1'b0;
                    w_bub      = 1'b1;
                    w_next     = MEM_WAIT;
                    w_wait_nxt = WC_W'(1);
                end else if (BranchTakenE) begin
                    w_flD = 1'b1;
                    w_flE = 1'b1;
                end else if (w_loaduse) begin
                    w_enF = 1'b0;
                    w_enD = 1'b0;
                    w_flE = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Release cycle lets every stage advance; hazards wait a cycle.
                if (mem_ready) begin
                    w_next = RUN;
                end else if (r_wait_cnt == WC_W'(TIMEOUT)) begin
                    w_enF  = 1'b0;
                    w_enD  = 1'b0;
                    w_enE  = 1'b0;
                    w_enM  = 1'b0;
                    w_bub  = 1'b1;
                    w_next = ERROR;
                end else begin
                    w_enF      = 1'b0;
                    w_enD      = 1'b0;
                    w_enE      = 1'b0;
                    w_enM      = 1'b0;
                    w_bub      = 1'b1;
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            ERROR: begin
                w_enF = 1'b0;
                w_enD = 1'b0;
                w_enE = 1'b0;
                w_enM = 1'b0;
                w_enW = 1'b0;
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    always_comb begin
        w_fa = 2'b00;
        if (RegWriteM && (WriteRegM != '0) && (WriteRegM == rsE))
            w_fa = 2'b10;
        else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == rsE))
            w_fa = 2'b01;
    end

    always_comb begin
        w_fb = 2'b00;
        if (RegWriteM && (WriteRegM != '0) && (WriteRegM == rtE))
            w_fb = 2'b10;
        else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == rtE))
            w_fb = 2'b01;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_terr      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
            if (w_next == ERROR)
                r_terr <= 1'b1;
            if (!w_enF && (r_state != ERROR) && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Reset forces every control output quiet, independent of state.
    assign enableF     = rst_n & w_enF;
    assign enableD     = rst_n & w_enD;
    assign enableE     = rst_n & w_enE;
    assign enableM     = rst_n & w_enM;
    assign enableW     = rst_n & w_enW;
    assign flushD      = rst_n & w_flD;
    assign flushE      = rst_n & w_flE;
    assign bubbleW     = rst_n & w_bub;
    assign ForwardAE   = rst_n ? w_fa : 2'b00;
    assign ForwardBE   = rst_n ? w_fb : 2'b00;
    assign stall_count = r_stall_cnt;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for RUN-state
// decoding plus hand sequences for reset, memory wait and timeout.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 6;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [REG_W-1:0] rsD, rtD, rsE, rtE;
    logic [REG_W-1:0] WriteRegE, WriteRegM, WriteRegW;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemtoRegE, MemAccessM, mem_ready, BranchTakenE;
    logic             enableF, enableD, enableE, enableM, enableW;
    logic             flushD, flushE, bubbleW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] stall_count;
    logic             timeout_err;

    pipeline_hazard_ctrl #(
        .REG_W   (REG_W),
        .TIMEOUT (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rsD          (rsD),
        .rtD          (rtD),
        .rsE          (rsE),
        .rtE          (rtE),
        .WriteRegE    (WriteRegE),
        .WriteRegM    (WriteRegM),
        .WriteRegW    (WriteRegW),
        .RegWriteE    (RegWriteE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .MemAccessM   (MemAccessM),
        .mem_ready    (mem_ready),
        .BranchTakenE (BranchTakenE),
        .enableF      (enableF),
        .enableD      (enableD),
        .enableE      (enableE),
        .enableM      (enableM),
        .enableW      (enableW),
        .flushD       (flushD),
        .flushE       (flushE),
        .bubbleW      (bubbleW),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .stall_count  (stall_count),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW, m2r, br;
        logic [11:0] exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_stall = 0;
    vec_t vecs[12];

    function automatic vec_t mk(
        input string n,
        input logic [5:0] a, b, c, d, e, f, g,
        input logic h, i, j, k, l,
        input logic [11:0] x
    );
        vec_t v;
        v.name = n;
        v.rsD = a; v.rtD = b; v.rsE = c; v.rtE = d;
        v.wE = e; v.wM = f; v.wW = g;
        v.rwE = h; v.rwM = i; v.rwW = j; v.m2r = k; v.br = l;
        v.exp = x;
        return v;
    endfunction

    function automatic logic [11:0] outs();
        return {enableF, enableD, enableE, enableM, enableW,
                flushD, flushE, bubbleW, ForwardAE, ForwardBE};
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemAccessM = 0; mem_ready = 0;
        BranchTakenE = 0;
    endtask

    localparam logic [11:0] IDLE  = 12'b11111_000_00_00;
    localparam logic [11:0] LU    = 12'b00111_010_00_00;
    localparam logic [11:0] BR    = 12'b11111_110_00_00;
    localparam logic [11:0] MWAIT = 12'b00001_001_00_00;

    int n;

    initial begin
        //          name      rsD rtD rsE rtE wE wM wW rwE rwM rwW m2r br exp
        vecs[0]  = mk("idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        vecs[1]  = mk("lu_rs",   5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, LU);
        vecs[2]  = mk("lu_rt",   1, 5, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, LU);
        vecs[3]  = mk("lu_r0",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, IDLE);
        vecs[4]  = mk("no_load", 5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, IDLE);
        vecs[5]  = mk("lu_miss", 4, 6, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, IDLE);
        vecs[6]  = mk("br_lu",   5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1, 1, BR);
        vecs[7]  = mk("br",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, BR);
        vecs[8]  = mk("fwd_m",   0, 0, 7, 0, 0, 7, 7, 0, 1, 1, 0, 0,
                      12'b11111_000_10_00);
        vecs[9]  = mk("fwd_w",   0, 0, 7, 0, 0, 7, 7, 0, 0, 1, 0, 0,
                      12'b11111_000_01_00);
        vecs[10] = mk("fwd_r0",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, IDLE);
        vecs[11] = mk("fwd_ab",  0, 0, 3, 7, 0, 7, 3, 0, 1, 1, 0, 0,
                      12'b11111_000_01_10);

        // Reset with memory stall, branch and a forward match all active.
        clear_in();
        rst_n = 0;
        MemAccessM = 1; BranchTakenE = 1;
        RegWriteM = 1; WriteRegM = 7; rsE = 7;
        tick();
        tick();
        chk("rst_outs", 32'(outs()), 32'(12'h000));
        chk("rst_stall", 32'(stall_count), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        clear_in();
        #1;
        rst_n = 1;
        #1;
        chk("rst_rel", 32'(outs()), 32'(IDLE));

        foreach (vecs[i]) begin
            rsD = vecs[i].rsD; rtD = vecs[i].rtD;
            rsE = vecs[i].rsE; rtE = vecs[i].rtE;
            WriteRegE = vecs[i].wE; WriteRegM = vecs[i].wM;
            WriteRegW = vecs[i].wW;
            RegWriteE = vecs[i].rwE; RegWriteM = vecs[i].rwM;
            RegWriteW = vecs[i].rwW;
            MemtoRegE = vecs[i].m2r; BranchTakenE = vecs[i].br;
            #1;
            chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
            if (!vecs[i].exp[11]) exp_stall++;
            tick();
        end
        chk("tbl_stall", 32'(stall_count), 32'(exp_stall));

        // Three-cycle memory wait; branch raised mid-wait must be ignored.
        clear_in();
        MemAccessM = 1;
        for (int k = 0; k < 3; k++) begin
            BranchTakenE = (k >= 1);
            #1;
            chk($sformatf("mw_%0d", k), 32'(outs()), 32'(MWAIT));
            exp_stall++;
            tick();
        end
        mem_ready = 1;
        #1;
        chk("mw_rel", 32'(outs()), 32'(IDLE));
        tick();
        clear_in();
        #1;
        chk("mw_run", 32'(outs()), 32'(IDLE));
        chk("mw_stall", 32'(stall_count), 32'(exp_stall));

        // Timeout with TIMEOUT=4: entry cycle plus four wait cycles.
        MemAccessM = 1;
        n = 0;
        while (!timeout_err && n < 20) begin
            tick();
            n++;
        end
        chk("to_cycles", 32'(n), 5);
        exp_stall += 5;
        chk("to_outs", 32'(outs()), 32'(12'h000));
        chk("to_stall", 32'(stall_count), 32'(exp_stall));
        clear_in();
        BranchTakenE = 1;
        tick();
        tick();
        tick();
        chk("err_sticky", 32'(timeout_err), 1);
        chk("err_outs", 32'(outs()), 32'(12'h000));
        chk("err_stall", 32'(stall_count), 32'(exp_stall));

        rst_n = 0;
        clear_in();
        tick();
        rst_n = 1;
        #1;
        chk("post_terr", 32'(timeout_err), 0);
        chk("post_outs", 32'(outs()), 32'(IDLE));
        chk("post_stall", 32'(stall_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
